// File: rtl/regfile_mp_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_pkg
// Shared constants and types for the multi-port register file with scoreboard.
//   XLEN           : default data width of one architectural register
//   NUM_REGS       : default number of architectural registers (power of two)
//   REG_ADDR_WIDTH : register address width derived from NUM_REGS
//   RESET_REG      : default reset value for registers 1..NUM_REGS-1
//   reg_addr_t     : register address type
//   xlen_t         : register data type
// ----------------------------------------------------------------------------
package regfile_mp_sb_pkg;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned NUM_REGS       = 32;
   localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);
   localparam logic [XLEN-1:0] RESET_REG  = '0;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]           xlen_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// ----------------------------------------------------------------------------
// regfile_bypass_mux
// Read-data select for a single read port. A write that is active in the
// current cycle and targets the read address is forwarded ahead of the stored
// array value. The highest-numbered matching write port wins. x0 always reads
// as zero and never reports a write hit.
// Ports:
//   i_rd_addr  : read address of this port
//   i_arr_data : stored array value at i_rd_addr
//   i_wr_en    : per write port valid
//   i_wr_addr  : per write port destination, packed N_WR x ADDR_W
//   i_wr_data  : per write port data, packed N_WR x DATA_W
//   o_rd_data  : bypassed read data
//   o_wr_hit   : some active write targets i_rd_addr (never set for x0)
// ----------------------------------------------------------------------------
module regfile_bypass_mux
   import regfile_mp_sb_pkg::*;
#(
   parameter int unsigned DATA_W = XLEN,
   parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
   parameter int unsigned N_WR   = 1
) (
   input  logic [ADDR_W-1:0]      i_rd_addr,
   input  logic [DATA_W-1:0]      i_arr_data,
   input  logic [N_WR-1:0]        i_wr_en,
   input  logic [N_WR*ADDR_W-1:0] i_wr_addr,
   input  logic [N_WR*DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0]      o_rd_data,
   output logic                   o_wr_hit
);

   always_comb begin
      o_rd_data = i_arr_data;
      o_wr_hit  = 1'b0;
      // Ascending scan: a later (higher-numbered) match overrides earlier ones.
      for (int k = 0; k < int'(N_WR); k++) begin
         if (i_wr_en[k] && (i_wr_addr[k*ADDR_W +: ADDR_W] == i_rd_addr)) begin
            o_rd_data = i_wr_data[k*DATA_W +: DATA_W];
            o_wr_hit  = 1'b1;
         end
      end
      if (i_rd_addr == '0) begin
         o_rd_data = '0;
         o_wr_hit  = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-read, multi-write integer register file with write-to-read bypass and a
// one-bit-per-register pending-write scoreboard. x0 is hard-wired to zero and
// is never pending.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-high
//   i_rd_addr    : NUM_RD x AW read addresses
//   o_rd_data    : NUM_RD x XLEN combinational, bypassed read data
//   o_rd_pending : NUM_RD addressed register still awaits a writeback
//   i_wr_en      : NUM_WR writeback valid
//   i_wr_addr    : NUM_WR x AW writeback destinations
//   i_wr_data    : NUM_WR x XLEN writeback data
//   i_alloc_en   : NUM_ALLOC issue allocates a destination
//   i_alloc_addr : NUM_ALLOC x AW allocated destinations
//   o_pending_vec: NUM_REGS registered scoreboard state, bit 0 always 0
// ----------------------------------------------------------------------------
module regfile_mp_sb #(
   parameter int unsigned XLEN      = regfile_mp_sb_pkg::XLEN,
   parameter int unsigned NUM_REGS  = regfile_mp_sb_pkg::NUM_REGS,
   parameter int unsigned NUM_RD    = 2,
   parameter int unsigned NUM_WR    = 1,
   parameter int unsigned NUM_ALLOC = 1,
   parameter logic [XLEN-1:0] RESET_VAL = regfile_mp_sb_pkg::RESET_REG,
   localparam int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_RD*AW-1:0]        i_rd_addr,
   output logic [NUM_RD*XLEN-1:0]      o_rd_data,
   output logic [NUM_RD-1:0]           o_rd_pending,
   input  logic [NUM_WR-1:0]           i_wr_en,
   input  logic [NUM_WR*AW-1:0]        i_wr_addr,
   input  logic [NUM_WR*XLEN-1:0]      i_wr_data,
   input  logic [NUM_ALLOC-1:0]        i_alloc_en,
   input  logic [NUM_ALLOC*AW-1:0]     i_alloc_addr,
   output logic [NUM_REGS-1:0]         o_pending_vec
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [XLEN-1:0]     r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_pending;

   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   logic [NUM_REGS-1:0] w_pending_d;

   logic [AW-1:0]       w_rd_addr  [NUM_RD];
   logic [XLEN-1:0]     w_arr_data [NUM_RD];
   logic [XLEN-1:0]     w_mux_data [NUM_RD];
   logic [NUM_RD-1:0]   w_wr_hit;

   // -------------------------------------------------------------------------
   // Register array. The reset branch has priority, so writes presented while
   // reset is high are ignored. Entry 0 is only ever loaded with zero.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < int'(NUM_REGS); r++) begin
            r_regs[r] <= (r == 0) ? '0 : RESET_VAL;
         end
      end else begin
         // Later port assignments take effect last, so the highest port wins.
         for (int k = 0; k < int'(NUM_WR); k++) begin
            if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] != '0)) begin
               r_regs[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*XLEN +: XLEN];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Scoreboard next state. Set is applied after clear so a same-cycle
   // allocation survives a writeback: the newer producer is outstanding.
   // -------------------------------------------------------------------------
   always_comb begin
      w_set = '0;
      w_clr = '0;
      for (int j = 0; j < int'(NUM_ALLOC); j++) begin
         if (i_alloc_en[j]) begin
            w_set[i_alloc_addr[j*AW +: AW]] = 1'b1;
         end
      end
      for (int k = 0; k < int'(NUM_WR); k++) begin
         if (i_wr_en[k]) begin
            w_clr[i_wr_addr[k*AW +: AW]] = 1'b1;
         end
      end
      w_pending_d    = (r_pending & ~w_clr) | w_set;
      w_pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_d;
      end
   end

   assign o_pending_vec = r_pending;

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      assign w_rd_addr[i]  = i_rd_addr[i*AW +: AW];
      assign w_arr_data[i] = r_regs[w_rd_addr[i]];

      regfile_bypass_mux #(
         .DATA_W (XLEN),
         .ADDR_W (AW),
         .N_WR   (NUM_WR)
      ) u_bypass (
         .i_rd_addr  (w_rd_addr[i]),
         .i_arr_data (w_arr_data[i]),
         .i_wr_en    (i_wr_en),
         .i_wr_addr  (i_wr_addr),
         .i_wr_data  (i_wr_data),
         .o_rd_data  (w_mux_data[i]),
         .o_wr_hit   (w_wr_hit[i])
      );

      // Outputs are forced quiet while reset is held.
      assign o_rd_data[i*XLEN +: XLEN] = reset ? '0 : w_mux_data[i];

      // A same-cycle writeback resolves the hazard because its data is
      // already forwarded; the mux never reports a hit for x0.
      assign o_rd_pending[i] = ~reset & r_pending[w_rd_addr[i]] & ~w_wr_hit[i]
                               & (w_rd_addr[i] != '0);
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed scenarios with literal expectations followed by randomized traffic.
// A behavioural model (plain arrays) tracks register contents and pending bits;
// a negedge process compares every DUT output against it each cycle.
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

   localparam int XLEN      = 32;
   localparam int NUM_REGS  = 32;
   localparam int AW        = 5;
   localparam int NUM_RD    = 3;
   localparam int NUM_WR    = 2;
   localparam int NUM_ALLOC = 2;

   logic clk = 1'b0;
   logic reset;

   logic [AW-1:0]        rd_addr    [NUM_RD];
   logic [NUM_WR-1:0]    wr_en;
   logic [AW-1:0]        wr_addr    [NUM_WR];
   logic [XLEN-1:0]      wr_data    [NUM_WR];
   logic [NUM_ALLOC-1:0] alloc_en;
   logic [AW-1:0]        alloc_addr [NUM_ALLOC];

   logic [NUM_RD*AW-1:0]    rd_addr_f;
   logic [NUM_RD*XLEN-1:0]  rd_data_f;
   logic [NUM_RD-1:0]       rd_pending;
   logic [NUM_WR*AW-1:0]    wr_addr_f;
   logic [NUM_WR*XLEN-1:0]  wr_data_f;
   logic [NUM_ALLOC*AW-1:0] alloc_addr_f;
   logic [NUM_REGS-1:0]     pending_vec;

   always #5 clk = ~clk;

   always_comb begin
      rd_addr_f = '0;
      for (int i = 0; i < NUM_RD; i++) rd_addr_f[i*AW +: AW] = rd_addr[i];
   end
   always_comb begin
      wr_addr_f = '0;
      wr_data_f = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_addr_f[k*AW +: AW]     = wr_addr[k];
         wr_data_f[k*XLEN +: XLEN] = wr_data[k];
      end
   end
   always_comb begin
      alloc_addr_f = '0;
      for (int j = 0; j < NUM_ALLOC; j++) alloc_addr_f[j*AW +: AW] = alloc_addr[j];
   end

   regfile_mp_sb #(
      .XLEN      (XLEN),
      .NUM_REGS  (NUM_REGS),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR),
      .NUM_ALLOC (NUM_ALLOC),
      .RESET_VAL (32'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_rd_addr     (rd_addr_f),
      .o_rd_data     (rd_data_f),
      .o_rd_pending  (rd_pending),
      .i_wr_en       (wr_en),
      .i_wr_addr     (wr_addr_f),
      .i_wr_data     (wr_data_f),
      .i_alloc_en    (alloc_en),
      .i_alloc_addr  (alloc_addr_f),
      .o_pending_vec (pending_vec)
   );

   // -------------------------------------------------------------------------
   // Scoring
   // -------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // -------------------------------------------------------------------------
   // Behavioural model
   // -------------------------------------------------------------------------
   logic [XLEN-1:0]     m_regs [NUM_REGS];
   logic [NUM_REGS-1:0] m_pend;

   function automatic bit any_write(input logic [AW-1:0] a);
      for (int k = 0; k < NUM_WR; k++) if (wr_en[k] && wr_addr[k] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (reset || a == 0) return '0;
      v = m_regs[a];
      for (int k = 0; k < NUM_WR; k++) if (wr_en[k] && wr_addr[k] == a) v = wr_data[k];
      return v;
   endfunction

   function automatic bit exp_pend(input logic [AW-1:0] a);
      return !reset && a != 0 && m_pend[a] && !any_write(a);
   endfunction

   function automatic logic [NUM_REGS-1:0] next_pending();
      logic [NUM_REGS-1:0] p;
      p = m_pend;
      for (int k = 0; k < NUM_WR; k++) if (wr_en[k]) p[wr_addr[k]] = 1'b0;
      for (int j = 0; j < NUM_ALLOC; j++) if (alloc_en[j]) p[alloc_addr[j]] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) m_regs[r] <= '0;
         m_pend <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++)
            if (wr_en[k] && wr_addr[k] != 0) m_regs[wr_addr[k]] <= wr_data[k];
         m_pend <= next_pending();
      end
   end

   // Compare process: every output, every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NUM_RD; i++) begin
            chk($sformatf("model rd_data[%0d] x%0d", i, rd_addr[i]),
                64'(rd_data_f[i*XLEN +: XLEN]), 64'(exp_data(rd_addr[i])));
            chk($sformatf("model rd_pending[%0d] x%0d", i, rd_addr[i]),
                64'(rd_pending[i]), 64'(exp_pend(rd_addr[i])));
         end
         chk("model pending_vec", 64'(pending_vec), 64'(m_pend));
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic idle();
      wr_en    = '0;
      alloc_en = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] raddr();
      if ($urandom_range(1, 0) == 0) return AW'($urandom_range(7, 0));
      return AW'($urandom_range(NUM_REGS - 1, 0));
   endfunction

   // -------------------------------------------------------------------------
   // Main sequence
   // -------------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      idle();
      for (int i = 0; i < NUM_RD; i++) rd_addr[i] = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_addr[k] = '0;
         wr_data[k] = '0;
      end
      for (int j = 0; j < NUM_ALLOC; j++) alloc_addr[j] = '0;

      tick();
      chk_en = 1'b1;

      // Reset held: reads quiet, writes ignored.
      wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'hFFFF_FFFF;
      alloc_en[0] = 1'b1; alloc_addr[0] = 5'd4;
      rd_addr[0] = 5'd4;
      @(negedge clk);
      chk("reset rd_data gated", 64'(rd_data_f[31:0]), 64'h0);
      chk("reset rd_pending gated", 64'(rd_pending[0]), 64'h0);
      tick();
      reset = 1'b0;
      idle();

      // Read x1..x31 after reset.
      for (int a = 1; a < NUM_REGS; a++) begin
         rd_addr[0] = AW'(a);
         @(negedge clk);
         chk($sformatf("post-reset x%0d", a), 64'(rd_data_f[31:0]), 64'h0);
         if (a == 1) chk("post-reset pending_vec", 64'(pending_vec), 64'h0);
         tick();
      end

      // Write x5 with same-cycle bypass, then stored value.
      wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
      rd_addr[0] = 5'd5;
      @(negedge clk);
      chk("bypass x5", 64'(rd_data_f[31:0]), 64'hDEAD_BEEF);
      tick();
      idle();
      @(negedge clk);
      chk("stored x5", 64'(rd_data_f[31:0]), 64'hDEAD_BEEF);
      tick();

      // x0 protection.
      wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234_5678;
      alloc_en[0] = 1'b1; alloc_addr[0] = 5'd0;
      rd_addr[0] = 5'd0;
      @(negedge clk);
      chk("x0 bypass blocked", 64'(rd_data_f[31:0]), 64'h0);
      tick();
      idle();
      @(negedge clk);
      chk("x0 read after write", 64'(rd_data_f[31:0]), 64'h0);
      chk("x0 never pending", 64'(pending_vec), 64'h0);
      tick();

      // Scoreboard lifecycle on x7 (cycle N = allocation cycle).
      alloc_en[1] = 1'b1; alloc_addr[1] = 5'd7;
      rd_addr[1] = 5'd7;
      @(negedge clk);
      chk("x7 alloc not visible in N", 64'(rd_pending[1]), 64'h0);
      tick();
      idle();
      @(negedge clk);
      chk("x7 pending N+1", 64'(rd_pending[1]), 64'h1);
      chk("x7 pending_vec N+1", 64'(pending_vec), 64'h80);
      tick();
      @(negedge clk);
      chk("x7 pending N+2", 64'(rd_pending[1]), 64'h1);
      tick();
      wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'h55;
      @(negedge clk);
      chk("x7 writeback hides pending", 64'(rd_pending[1]), 64'h0);
      chk("x7 writeback bypass", 64'(rd_data_f[63:32]), 64'h55);
      tick();
      idle();
      @(negedge clk);
      chk("x7 pending_vec N+4", 64'(pending_vec[7]), 64'h0);
      chk("x7 stored", 64'(rd_data_f[63:32]), 64'h55);
      tick();

      // Set/clear collision on x9.
      alloc_en[0] = 1'b1; alloc_addr[0] = 5'd9;
      tick();
      alloc_en[0] = 1'b1; alloc_addr[0] = 5'd9;
      wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5;
      rd_addr[2] = 5'd9;
      @(negedge clk);
      chk("x9 collision bypass", 64'(rd_data_f[95:64]), 64'hA5);
      chk("x9 collision rd_pending", 64'(rd_pending[2]), 64'h0);
      tick();
      idle();
      @(negedge clk);
      chk("x9 set wins", 64'(pending_vec[9]), 64'h1);
      chk("x9 data", 64'(rd_data_f[95:64]), 64'hA5);
      chk("x9 rd_pending", 64'(rd_pending[2]), 64'h1);
      tick();

      // Two write ports on x3, then reset while x3 is pending.
      wr_en = 2'b11;
      wr_addr[0] = 5'd3; wr_data[0] = 32'h1;
      wr_addr[1] = 5'd3; wr_data[1] = 32'h2;
      rd_addr[0] = 5'd3;
      @(negedge clk);
      chk("x3 port conflict bypass", 64'(rd_data_f[31:0]), 64'h2);
      tick();
      idle();
      alloc_en[1] = 1'b1; alloc_addr[1] = 5'd3;
      @(negedge clk);
      chk("x3 port conflict stored", 64'(rd_data_f[31:0]), 64'h2);
      tick();
      idle();
      @(negedge clk);
      chk("x3 and x9 pending", 64'(pending_vec), 64'h208);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("x3 reset gates data", 64'(rd_data_f[31:0]), 64'h0);
      chk("x3 reset gates pending", 64'(rd_pending[0]), 64'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset clears scoreboard", 64'(pending_vec), 64'h0);
      chk("x3 reset value", 64'(rd_data_f[31:0]), 64'h0);
      tick();

      // Randomized traffic, occasional reset.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(63, 0) == 0);
         for (int i = 0; i < NUM_RD; i++) rd_addr[i] = raddr();
         for (int k = 0; k < NUM_WR; k++) begin
            wr_en[k]   = ($urandom_range(2, 0) != 0);
            wr_addr[k] = raddr();
            wr_data[k] = $urandom;
         end
         for (int j = 0; j < NUM_ALLOC; j++) begin
            alloc_en[j]   = ($urandom_range(1, 0) != 0);
            alloc_addr[j] = raddr();
         end
         tick();
      end

      reset = 1'b0;
      idle();
      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
